// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS32-style multiply/divide unit with HI/LO registers.
// Radix-2 shift-add multiply and restoring shift-subtract divide. Each operation
// passes through IDLE -> CALC -> FIXUP. Define EARLY_TERM_EN to let a multiply
// leave CALC as soon as its remaining multiplier bits are zero, and to send a
// divide by zero straight from IDLE to FIXUP.
module mult_div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic            hi_we,
   input  logic            lo_we,
   input  logic [XLEN-1:0] wdata,
   output logic            busy,
   output logic            done,
   output logic            div_by_zero,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

   state_t              state;
   logic                is_div;     // operation is DIV/DIVU
   logic                neg_res;    // product/quotient must be negated
   logic                neg_rem;    // remainder must be negated (dividend was negative)
   logic                dz;         // divide with zero divisor
   logic [XLEN-1:0]     mca;        // multiplicand magnitude or divisor magnitude
   logic [XLEN-1:0]     mb;         // remaining multiplier bits
   logic [2*XLEN-1:0]   acc;        // product accumulator, or {remainder, quotient}
   logic [CW-1:0]       cnt;        // steps remaining
   logic [XLEN-1:0]     a_raw;      // untouched dividend, returned in HI on divide by zero

   // Operand magnitudes for the incoming operation
   logic            sgn_op;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] abs_a;
   logic [XLEN-1:0] abs_b;

   // One radix-2 step of each algorithm
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     rem_shift;
   logic              rem_ge;
   logic [XLEN:0]     rem_sub;
   logic [2*XLEN-1:0] div_next;
   logic [XLEN-1:0]   mb_next;

   // Final results for FIXUP
   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_signed;
   logic [XLEN-1:0]   quo_fix;
   logic [XLEN-1:0]   rem_fix;

   // Operand sign handling: signed ops take the two's-complement absolute value
   always_comb begin
      sgn_op = op[0];
      a_neg  = sgn_op & src_a[XLEN-1];
      b_neg  = sgn_op & src_b[XLEN-1];
      abs_a  = a_neg ? (~src_a + 1'b1) : src_a;
      abs_b  = b_neg ? (~src_b + 1'b1) : src_b;
   end

   // Datapath for one multiply step, one divide step, and the final sign fixup
   always_comb begin
      // Multiply: add multiplicand into the upper half, then shift right by one
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (mb[0] ? {1'b0, mca} : {(XLEN+1){1'b0}});
      mul_next = {mul_sum, acc[XLEN-1:1]};
      mb_next  = mb >> 1;

      // Divide: shift the next dividend bit into the remainder, subtract if it fits
      rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      rem_ge    = (rem_shift >= {1'b0, mca});
      rem_sub   = rem_ge ? (rem_shift - {1'b0, mca}) : rem_shift;
      div_next  = {rem_sub[XLEN-1:0], acc[XLEN-2:0], rem_ge};

`ifdef EARLY_TERM_EN
      // An early exit leaves the partial product cnt positions too far left
      prod = acc >> cnt;
`else
      prod = acc;
`endif
      prod_signed = neg_res ? (~prod + 1'b1) : prod;
      quo_fix     = neg_res ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
      rem_fix     = neg_rem ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
   end

   // Control FSM with registered busy/done/flag and HI/LO result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         is_div      <= 1'b0;
         neg_res     <= 1'b0;
         neg_rem     <= 1'b0;
         dz          <= 1'b0;
         mca         <= '0;
         mb          <= '0;
         acc         <= '0;
         cnt         <= '0;
         a_raw       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // MTHI/MTLO; an accepted start on the same edge is overwritten later
               if (hi_we) hi <= wdata;
               if (lo_we) lo <= wdata;
               if (start) begin
                  is_div      <= op[1];
                  neg_res     <= a_neg ^ b_neg;
                  neg_rem     <= a_neg;
                  dz          <= op[1] & (src_b == '0);
                  mca         <= op[1] ? abs_b : abs_a;
                  mb          <= abs_b;
                  acc         <= op[1] ? {{XLEN{1'b0}}, abs_a} : {(2*XLEN){1'b0}};
                  a_raw       <= src_a;
                  cnt         <= CW'(XLEN);
                  busy        <= 1'b1;
                  div_by_zero <= 1'b0;
`ifdef EARLY_TERM_EN
                  state       <= (op[1] && (src_b == '0)) ? FIXUP : CALC;
`else
                  state       <= CALC;
`endif
               end
            end
            CALC: begin
               cnt <= cnt - 1'b1;
               if (is_div) begin
                  acc <= div_next;
               end else begin
                  acc <= mul_next;
                  mb  <= mb_next;
               end
`ifdef EARLY_TERM_EN
               if ((cnt == CW'(1)) || (!is_div && (mb_next == '0)))
                  state <= FIXUP;
`else
               if (cnt == CW'(1))
                  state <= FIXUP;
`endif
            end
            FIXUP: begin
               if (!is_div) begin
                  hi <= prod_signed[2*XLEN-1:XLEN];
                  lo <= prod_signed[XLEN-1:0];
               end else if (dz) begin
                  hi <= a_raw;
                  lo <= '1;
               end else begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end
               div_by_zero <= dz;
               done        <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit at XLEN=32 (default build).
module tb_mult_div_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks;
   int errors;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   mult_div_unit #(.XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .src_a       (src_a),
      .src_b       (src_b),
      .hi_we       (hi_we),
      .lo_we       (lo_we),
      .wdata       (wdata),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch one operation and wait (bounded) for done; lat=0 means timeout
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output bit busy_ok);
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      busy_ok = busy;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
         if (!busy) busy_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      checks += 5;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
      if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %0b want 0", div_by_zero); end
      if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 00000000", hi); end
      if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 00000000", lo); end
      @(negedge clk);
      rst = 1'b1;
      $display("reset: busy=%0b done=%0b hi=%h lo=%h", busy, done, hi, lo);
   endtask

   task automatic test_multu();
      int lat; bit bok;
      run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bok);
      checks += 4;
      if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
      if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
      if (lat !== 33) begin errors++; $display("FAIL multu_latency got %0d want 33", lat); end
      if (bok !== 1'b1) begin errors++; $display("FAIL multu_busy got %0b want 1", bok); end
      $display("MULTU ffffffff*ffffffff: hi=%h lo=%h latency=%0d", hi, lo, lat);
   endtask

   task automatic test_mult();
      int lat; bit bok;
      run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, lat, bok);
      checks += 2;
      if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_neg_hi got %h want ffffffff", hi); end
      if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_neg_lo got %h want ffffffeb", lo); end
      $display("MULT -3*7: hi=%h lo=%h", hi, lo);
      run_op(OP_MULT, 32'h80000000, 32'h80000000, lat, bok);
      checks += 2;
      if (hi !== 32'h40000000) begin errors++; $display("FAIL mult_min_hi got %h want 40000000", hi); end
      if (lo !== 32'h00000000) begin errors++; $display("FAIL mult_min_lo got %h want 00000000", lo); end
      $display("MULT min*min: hi=%h lo=%h", hi, lo);
   endtask

   task automatic test_div();
      int lat; bit bok;
      run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, bok);
      checks += 3;
      if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo got %h want fffffffd", lo); end
      if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi got %h want ffffffff", hi); end
      if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d want 33", lat); end
      $display("DIV -7/2: lo=%h hi=%h latency=%0d", lo, hi, lat);
      run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bok);
      checks += 3;
      if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
      if (hi !== 32'h00000000) begin errors++; $display("FAIL div_ovf_hi got %h want 00000000", hi); end
      if (div_by_zero !== 1'b0) begin errors++; $display("FAIL div_ovf_dz got %0b want 0", div_by_zero); end
      $display("DIV min/-1: lo=%h hi=%h dz=%0b", lo, hi, div_by_zero);
      run_op(OP_DIVU, 32'd100, 32'd7, lat, bok);
      checks += 2;
      if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %0d want 14", lo); end
      if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi got %0d want 2", hi); end
      $display("DIVU 100/7: lo=%0d hi=%0d", lo, hi);
   endtask

   task automatic test_divzero();
      int lat; bit bok;
      run_op(OP_DIVU, 32'd5, 32'd0, lat, bok);
      checks += 4;
      if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_lo got %h want ffffffff", lo); end
      if (hi !== 32'd5) begin errors++; $display("FAIL dz_hi got %h want 00000005", hi); end
      if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %0b want 1", div_by_zero); end
      if (lat !== 33) begin errors++; $display("FAIL dz_latency got %0d want 33", lat); end
      $display("DIVU 5/0: lo=%h hi=%h dz=%0b latency=%0d", lo, hi, div_by_zero, lat);
      // Flag must hold in idle, then clear on the next accepted start
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_hold got %0b want 1", div_by_zero); end
      @(negedge clk);
      start = 1'b1; op = OP_MULTU; src_a = 32'd2; src_b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_clear got %0b want 0", div_by_zero); end
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (done) break;
      end
      checks++;
      if (lo !== 32'd6) begin errors++; $display("FAIL dz_next_lo got %0d want 6", lo); end
      $display("after dz: next MULTU 2*3 lo=%0d dz=%0b", lo, div_by_zero);
   endtask

   task automatic test_mthi_mtlo();
      int lat; bit bok;
      @(negedge clk);
      hi_we = 1'b1; wdata = 32'h1234;
      @(posedge clk); #1;
      hi_we = 1'b0;
      checks++;
      if (hi !== 32'h1234) begin errors++; $display("FAIL mthi got %h want 00001234", hi); end
      @(negedge clk);
      lo_we = 1'b1; wdata = 32'h5678;
      @(posedge clk); #1;
      lo_we = 1'b0;
      checks++;
      if (lo !== 32'h5678) begin errors++; $display("FAIL mtlo got %h want 00005678", lo); end
      $display("MTHI/MTLO idle: hi=%h lo=%h", hi, lo);
      // Strobes during an operation are ignored and HI/LO hold through CALC
      @(negedge clk);
      start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b0;
      checks += 2;
      if (hi !== 32'h1234) begin errors++; $display("FAIL mthi_busy got %h want 00001234", hi); end
      if (lo !== 32'h5678) begin errors++; $display("FAIL mtlo_busy got %h want 00005678", lo); end
      lat = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (done) begin lat = 1; break; end
      end
      checks += 2;
      if (hi !== 32'd0) begin errors++; $display("FAIL mt_busy_res_hi got %h want 00000000", hi); end
      if (lo !== 32'd15) begin errors++; $display("FAIL mt_busy_res_lo got %0d want 15", lo); end
      $display("MTHI/MTLO during busy: result hi=%h lo=%h", hi, lo);
      // Both strobes together write both registers
      @(negedge clk);
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b0;
      checks += 2;
      if (hi !== 32'hCAFE) begin errors++; $display("FAIL mt_both_hi got %h want 0000cafe", hi); end
      if (lo !== 32'hCAFE) begin errors++; $display("FAIL mt_both_lo got %h want 0000cafe", lo); end
      $display("MTHI+MTLO together: hi=%h lo=%h", hi, lo);
      run_op(OP_MULTU, 32'd1, 32'd1, lat, bok);
   endtask

   task automatic test_busy_ignore();
      int dones;
      int first_lat;
      @(negedge clk);
      start = 1'b1; op = OP_MULTU; src_a = 32'd2; src_b = 32'd2;
      @(posedge clk); #1;
      start = 1'b0;
      dones = 0;
      first_lat = 0;
      for (int i = 1; i <= 60; i++) begin
         if (i == 5) begin
            start = 1'b1; src_a = 32'd9; src_b = 32'd9;
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin
            dones++;
            if (first_lat == 0) first_lat = i;
         end
      end
      checks += 3;
      if (dones !== 1) begin errors++; $display("FAIL busy_ignore_dones got %0d want 1", dones); end
      if (first_lat !== 33) begin errors++; $display("FAIL busy_ignore_latency got %0d want 33", first_lat); end
      if (lo !== 32'd4) begin errors++; $display("FAIL busy_ignore_lo got %0d want 4", lo); end
      $display("start during busy: dones=%0d latency=%0d lo=%0d", dones, first_lat, lo);
   endtask

   task automatic test_reset_midop();
      int dones;
      int lat; bit bok;
      @(negedge clk);
      start = 1'b1; op = OP_MULTU; src_a = 32'd7; src_b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checks += 3;
      if (hi !== 32'd0) begin errors++; $display("FAIL rst_mid_hi got %h want 00000000", hi); end
      if (lo !== 32'd0) begin errors++; $display("FAIL rst_mid_lo got %h want 00000000", lo); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %0b want 0", busy); end
      @(negedge clk);
      rst = 1'b1;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      checks++;
      if (dones !== 0) begin errors++; $display("FAIL rst_mid_done got %0d want 0", dones); end
      $display("reset mid-op: hi=%h lo=%h dones_after=%0d", hi, lo, dones);
      run_op(OP_MULTU, 32'd3, 32'd1, lat, bok);
      checks += 2;
      if (lo !== 32'd3) begin errors++; $display("FAIL rst_after_lo got %0d want 3", lo); end
      if (lat !== 33) begin errors++; $display("FAIL rst_after_latency got %0d want 33", lat); end
      $display("after reset MULTU 3*1: lo=%0d latency=%0d", lo, lat);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_multu();
      test_mult();
      test_div();
      test_divzero();
      test_mthi_mtlo();
      test_busy_ignore();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
